// File: rtl/mant_alu_pkg.sv
// Shared opcode constants, FSM state type and result flag bundle for the
// mantissa ALU pipeline.
package mant_alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_PASSB  = 4'b0111;
  localparam logic [3:0] OP_PASSBM = 4'b1000;
  localparam logic [3:0] OP_SHR    = 4'b1001;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic sticky;
  } flags_t;

endpackage

// File: rtl/mant_alu_core.sv
// Combinational single-cycle datapath: logic ops, add/sub with carry and
// signed overflow, pass/negate of B. Unknown codes (and SHR, which the
// pipeline handles itself) produce zero.
module mant_alu_core
  import mant_alu_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] w,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // Zero-extended so bit WIDTH is the carry-out (ADD) or the borrow (SUB).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Result and arithmetic flags selected by opcode.
  always_comb begin
    w        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND:    w = a & b;
      OP_OR:     w = a | b;
      OP_ADD: begin
        w        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w        = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASSB:  w = b;
      OP_PASSBM: w = '0 - b;
      default:   w = '0;
    endcase
  end

  assign zero = (w == '0);

endmodule

// File: rtl/mant_alu_pipe.sv
// Handshaked mantissa ALU: single-cycle ops complete on the accepting edge,
// SHR shifts one bit per cycle with a sticky accumulator. One output
// register with valid/ready back-pressure.
module mant_alu_pipe
  import mant_alu_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int SHW   = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Sticky
);

  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   K_MAX   = SHW'(WIDTH);
  localparam logic [SHW-1:0]   K_ONE   = SHW'(1);

  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic             stk_reg, stk_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] busw_reg, busw_next;
  flags_t           flags_reg, flags_next;

  logic [WIDTH-1:0] core_w;
  logic             core_carry, core_overflow, core_zero;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;
  logic             out_block, accept, is_shr;

  mant_alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (BusA),
    .b        (BusB),
    .op       (ALUCtrl),
    .w        (core_w),
    .carry    (core_carry),
    .overflow (core_overflow),
    .zero     (core_zero)
  );

  // Any B at or above WIDTH saturates, so every bit of A is shifted out.
  assign shamt     = (BusB >= W_LIMIT) ? K_MAX : BusB[SHW-1:0];
  assign shifted   = {1'b0, work_reg[WIDTH-1:1]};
  assign out_block = out_valid_reg && !OutReady;
  assign InReady   = (state_reg == IDLE) && !out_block;
  assign accept    = InValid && InReady;
  assign is_shr    = (ALUCtrl == OP_SHR);

  // Next-state, shifter and output-register update.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    work_next      = work_reg;
    stk_next       = stk_reg;
    busw_next      = busw_reg;
    flags_next     = flags_reg;
    out_valid_next = out_block;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_shr && (shamt != '0)) begin
            state_next = SHIFT;
            cnt_next   = shamt;
            work_next  = BusA;
            stk_next   = 1'b0;
          end else begin
            out_valid_next = 1'b1;
            flags_next     = '0;
            if (is_shr) begin
              busw_next       = BusA;
              flags_next.zero = (BusA == '0);
            end else begin
              busw_next           = core_w;
              flags_next.zero     = core_zero;
              flags_next.carry    = core_carry;
              flags_next.overflow = core_overflow;
            end
          end
        end
      end
      SHIFT: begin
        // Only the final shift writes the output register, so only it waits.
        if ((cnt_reg != K_ONE) || !out_block) begin
          work_next = shifted;
          stk_next  = stk_reg | work_reg[0];
          cnt_next  = cnt_reg - K_ONE;
          if (cnt_reg == K_ONE) begin
            state_next      = IDLE;
            out_valid_next  = 1'b1;
            busw_next       = shifted;
            flags_next      = '0;
            flags_next.zero = (shifted == '0);
            flags_next.sticky = stk_reg | work_reg[0];
          end
        end
      end
    endcase
  end

  // State and result registers; reset abandons any shift in progress.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      work_reg      <= '0;
      stk_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busw_reg      <= '0;
      flags_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      work_reg      <= work_next;
      stk_reg       <= stk_next;
      out_valid_reg <= out_valid_next;
      busw_reg      <= busw_next;
      flags_reg     <= flags_next;
    end
  end

  assign OutValid = out_valid_reg;
  assign BusW     = busw_reg;
  assign Zero     = flags_reg.zero;
  assign Carry    = flags_reg.carry;
  assign Overflow = flags_reg.overflow;
  assign Sticky   = flags_reg.sticky;

endmodule

// File: doc/mant_alu_pipe.md
MANT_ALU_PIPE -- requirements
Module: mant_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 23, operand/result width in bits (legal range 4..64).
REQ-002 Parameter SHW, default $clog2(WIDTH+1), shift-amount field width.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 InValid  input  1  operation request valid.
REQ-006 InReady  output  1  block can accept a request this cycle.
REQ-007 BusA  input  WIDTH  operand A.
REQ-008 BusB  input  WIDTH  operand B; for SHR, BusB[SHW-1:0] is the shift amount.
REQ-009 ALUCtrl  input  4  operation code.
REQ-010 OutValid  output  1  result register holds an unconsumed result.
REQ-011 OutReady  input  1  consumer accepts the result this cycle.
REQ-012 BusW  output  WIDTH  registered result.
REQ-013 Zero, Carry, Overflow, Sticky  output  1 each  registered flags accompanying BusW.

Function
REQ-014 Opcodes SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, PassB=0111, PassBM=1000, SHR=1001; any other code yields BusW=0 and all flags 0 except Zero=1.
REQ-015 AND/OR are bitwise; PassB gives BusB; PassBM gives the two's-complement negation of BusB (mod 2^WIDTH).
REQ-016 ADD/SUB SHALL compute modulo 2^WIDTH; Carry = unsigned carry-out (ADD) or borrow, i.e. A<B unsigned (SUB); Overflow = signed two's-complement overflow; both are 0 for every other op.
REQ-017 Zero SHALL equal (BusW==0) for every op; Sticky is 0 for every op except SHR.
REQ-018 Handshake: a request transfers on a rising edge with InValid && InReady; the output transfers on a rising edge with OutValid && OutReady.
REQ-019 InReady SHALL be (state==IDLE) && (!OutValid || OutReady), combinationally.
REQ-020 Single-cycle ops (all except SHR, and SHR with amount 0) SHALL load BusW/flags and set OutValid on the accepting edge (latency 1), sustaining one op per cycle when OutReady is held high.
REQ-021 FSM states: IDLE, SHIFT. IDLE->SHIFT on acceptance of SHR with amount k>=1; SHIFT->IDLE on the edge that loads the SHR result.
REQ-022 SHR amount k SHALL be clamped to WIDTH; the accepting edge loads the working register with BusA, the counter with k, and clears the sticky accumulator.
REQ-023 In SHIFT, each edge SHALL shift the working register right logically by 1, OR the shifted-out bit into the sticky accumulator, and decrement the counter.
REQ-024 The shift that takes the counter 1->0 SHALL also load BusW/Sticky/Zero and set OutValid; it SHALL stall (no shift, no decrement) while OutValid && !OutReady.
REQ-025 SHR latency SHALL therefore be max(1,k) cycles when unblocked; k>=WIDTH gives BusW=0, Sticky=|BusA, Zero=1.
REQ-026 When a result is consumed and a new one is loaded on the same edge, OutValid SHALL stay 1; when consumed with nothing loaded, OutValid SHALL fall to 0.
REQ-027 BusW and flags SHALL hold their value while OutValid && !OutReady.

Reset
REQ-028 While Rst_n=0: state=IDLE, OutValid=0, BusW=0, Zero=0, Carry=0, Overflow=0, Sticky=0, counter, working register and sticky accumulator =0.
REQ-029 Reset asserted mid-SHR SHALL discard the operation; no result is produced after release.
REQ-030 InReady SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Package mant_alu_pkg SHALL hold the opcode constants and the FSM state type.
REQ-032 Combinational single-cycle datapath (AND/OR/ADD/SUB/PassB/PassBM plus flags) SHALL be sub-module mant_alu_core, parametrised by WIDTH; shifter, FSM and output register live in mant_alu_pipe.

Verification (WIDTH=23)
REQ-033 ADD A=7FFFFF, B=000001, OutReady=1 -> next cycle BusW=000000, Zero=1, Carry=1, Overflow=0, OutValid=1.
REQ-034 SUB A=000000, B=000001 -> BusW=7FFFFF, Carry=1, Overflow=0; ADD A=3FFFFF, B=000001 -> BusW=400000, Overflow=1, Carry=0.
REQ-035 PassBM B=000001 -> BusW=7FFFFF; unused code 1111 -> BusW=0, Zero=1.
REQ-036 SHR A=400003, B=3 -> InReady low 3 cycles, OutValid 3 cycles after accept, BusW=080000, Sticky=1; B=40 -> BusW=0, Sticky=1 after 23 cycles.
REQ-037 Back-to-back ADDs with OutReady toggling 1,0,1 -> no result lost or duplicated, BusW stable while stalled, InReady=0 during the stall.
REQ-038 Rst_n pulsed low during SHR with B=10 -> OutValid=0, all outputs 0, InReady=1 after release, no late result.
